fonte_operandos_somador: RTL

Operand source and controller for the summation datapath. It buffers up to DEPTH signed operands written by a host, starts an accumulation on the adder state machine, and streams the operands one per clock. It then waits for the adder's `pronto`, captures the sum and overflow flag, and reports completion to the host. It is the initiator side of the adder handshake: it drives `inicio` and `valor`, and consumes `pronto`, `soma` and `overflow`.

---
 rtl/fonte_operandos_somador.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fonte_operandos_somador.sv
// Operand buffer and initiator for the summation adder: collects host operands,
// streams them to the adder after go, then captures the returned sum or times out.
//
// state   | meaning
// S_IDLE  | host may write operands; go starts a batch when the buffer is non-empty
// S_START | one-cycle inicio pulse to the adder
// S_SEND  | present buffer[i] on valor, one operand per clock
// S_WAIT  | wait for pronto, bounded by TIMEOUT
// S_DONE  | one-cycle concluido; buffer emptied
module fonte_operandos_somador #(
    parameter int W       = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         go,
    output logic         cheio,
    output logic         ocupado,
    output logic         inicio,
    output logic [W-1:0] valor,
    output logic         valor_valid,
    output logic         valor_ultimo,
    input  logic         pronto,
    input  logic [W-1:0] soma_in,
    input  logic         overflow_in,
    output logic [W-1:0] resultado,
    output logic         resultado_ovf,
    output logic         erro,
    output logic         concluido
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] N_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] n;
    logic [IW-1:0] i;
    logic [7:0]    wait_cnt;
    logic [W-1:0]  buf_mem [DEPTH];

    logic last_op;
    logic timeout_hit;
    logic start_ok;
    logic wr_accept;

    always_comb begin
        last_op     = (CW'(i) == (n - CW'(1)));
        timeout_hit = (wait_cnt == 8'd0);
        start_ok    = go && (n != '0);
        wr_accept   = (state == S_IDLE) && wr_en && (n != N_FULL) && !start_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_START;
            S_START: state_nxt = S_SEND;
            S_SEND:  if (last_op) state_nxt = S_WAIT;
            S_WAIT:  if (pronto || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        inicio       = (state == S_START);
        valor_valid  = (state == S_SEND);
        valor_ultimo = (state == S_SEND) && last_op;
        valor        = (state == S_SEND) ? buf_mem[i] : '0;
        ocupado      = (state != S_IDLE);
        concluido    = (state == S_DONE);
        cheio        = (n == N_FULL);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_mem[n[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n             <= '0;
            i             <= '0;
            wait_cnt      <= 8'd0;
            resultado     <= '0;
            resultado_ovf <= 1'b0;
            erro          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    i <= '0;
                    if (wr_accept) n <= n + CW'(1);
                end
                S_SEND: begin
                    if (last_op) wait_cnt <= 8'(TIMEOUT);
                    else         i <= i + IW'(1);
                end
                S_WAIT: begin
                    // pronto wins over an expiring timer in the same cycle
                    if (pronto) begin
                        resultado     <= soma_in;
                        resultado_ovf <= overflow_in;
                        erro          <= 1'b0;
                    end else if (timeout_hit) begin
                        erro <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_DONE: n <= '0;
                default: ;
            endcase
        end
    end

endmodule
